// File: rtl/shared_pkg.sv
// Shared types and constants for the APB register-file front-ends.
package shared_pkg;

  // Two-state encoding used by the basic zero-wait APB slave.
  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_e;

  // Three-state encoding used by the wait-state APB slave.
  typedef enum logic [1:0] {
    WS_IDLE,
    WS_WAIT,
    WS_RESP
  } apb_ws_state_e;

  // Largest wait-state count the 8-bit wait counter can hold.
  localparam int APB_MAX_WAIT = 255;

endpackage : shared_pkg

// File: rtl/apb_slave_decode.sv
// Combinational access check for the APB slave: flags addresses outside the
// register window, word-misaligned addresses and reads carrying strobes.
module apb_slave_decode
  import shared_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    NUM_REGS   = 16,
  parameter int                    NBYTES     = 4
) (
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [NBYTES-1:0]     PSTRB,
  output logic                  err
);

  // One extra bit on the window bounds so BASE_ADDR + size cannot wrap.
  localparam int                  AW1        = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] WIN_LO     = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI     = WIN_LO + AW1'(NUM_REGS * NBYTES);
  localparam int                  ALIGN_BITS = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [ADDR_WIDTH:0] addr_ext;
  logic                below;
  logic                above;
  logic                misaligned;
  logic                bad_strb;

  // Window, alignment and strobe checks combined into a single error flag.
  always_comb begin
    addr_ext   = {1'b0, PADDR};
    below      = addr_ext < WIN_LO;
    above      = addr_ext >= WIN_HI;
    misaligned = 1'b0;
    if (NBYTES > 1) begin
      misaligned = |PADDR[ALIGN_BITS-1:0];
    end
    bad_strb   = ~PWRITE & (|PSTRB);
    err        = below | above | misaligned | bad_strb;
  end

endmodule : apb_slave_decode

// File: rtl/apb_slave_ws.sv
// APB4 slave front-end with programmable wait states, read-data return,
// address/alignment error response and abort on protocol violation.
module apb_slave_ws
  import shared_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NBYTES      = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSELx,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [NBYTES-1:0]     PSTRB,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PENABLE,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  write_en,
  output logic                  read_en,
  output logic [NBYTES-1:0]     byte_strobe,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam int        WAIT_CLAMP = (WAIT_CYCLES > APB_MAX_WAIT) ? APB_MAX_WAIT : WAIT_CYCLES;
  localparam logic [7:0] WAIT_LD   = 8'(WAIT_CLAMP);

  apb_ws_state_e         state_q, state_d;
  logic [7:0]            cnt_q;
  logic                  write_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NBYTES-1:0]     strb_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  setup;
  logic                  access;
  logic                  dec_err;

  assign setup  = PSELx & ~PENABLE;
  assign access = PSELx & PENABLE;

  apb_slave_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .NUM_REGS   (NUM_REGS),
    .NBYTES     (NBYTES)
  ) u_decode (
    .PADDR  (PADDR),
    .PWRITE (PWRITE),
    .PSTRB  (PSTRB),
    .err    (dec_err)
  );

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= WS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept setup in IDLE, count wait states, one-cycle response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WS_IDLE: begin
        if (setup) begin
          state_d = (WAIT_CLAMP > 0) ? WS_WAIT : WS_RESP;
        end
      end
      WS_WAIT: begin
        if (!access) begin
          state_d = WS_IDLE;
        end else if (cnt_q == 8'd1) begin
          state_d = WS_RESP;
        end
      end
      WS_RESP: state_d = WS_IDLE;
      default: state_d = WS_IDLE;
    endcase
  end

  // Transfer capture on setup and wait-state counter.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == WS_IDLE) begin
      if (setup) begin
        cnt_q   <= WAIT_LD;
        write_q <= PWRITE;
        err_q   <= dec_err;
        addr_q  <= PADDR - BASE_ADDR;
        strb_q  <= PSTRB;
        wdata_q <= PWDATA;
      end
    end else if (state_q == WS_WAIT) begin
      // An aborted transfer leaves the counter cleared rather than mid-count.
      cnt_q <= access ? (cnt_q - 8'd1) : '0;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    PREADY   = 1'b0;
    PSLVERR  = 1'b0;
    PRDATA   = '0;
    write_en = 1'b0;
    read_en  = 1'b0;
    if (state_q == WS_RESP) begin
      PREADY   = 1'b1;
      PSLVERR  = err_q;
      write_en = write_q & ~err_q;
      if (~write_q & ~err_q) begin
        PRDATA = rdata;
      end
    end
    if ((state_q == WS_WAIT) || (state_q == WS_RESP)) begin
      read_en = ~write_q & ~err_q;
    end
  end

  assign addr        = addr_q;
  assign byte_strobe = strb_q;
  assign wdata       = wdata_q;

endmodule : apb_slave_ws

// File: tb/tb_apb_slave_ws.sv
// Directed bench for apb_slave_ws: four instances with wait states 0/2/3/4
// share one APB bus, each with its own select and register-file model.
module tb_apb_slave_ws;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  psel = '0;
  logic [31:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic [3:0]  pstrb = '0;
  logic [31:0] pwdata = '0;
  logic        penable = 1'b0;

  logic [3:0]  pready, pslverr, wen, ren;
  logic [31:0] prdata [4];
  logic [31:0] addr_o [4];
  logic [31:0] wdata_o [4];
  logic [31:0] rdata [4];
  logic [3:0]  bstrb [4];
  logic [31:0] mem [4][16];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    apb_slave_ws #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .BASE_ADDR   (BASE),
      .NUM_REGS    (16),
      .WAIT_CYCLES ((g == 0) ? 0 : g + 1)
    ) u_dut (
      .PCLK        (clk),
      .PRESET      (rst),
      .PSELx       (psel[g]),
      .PADDR       (paddr),
      .PWRITE      (pwrite),
      .PSTRB       (pstrb),
      .PWDATA      (pwdata),
      .PENABLE     (penable),
      .PREADY      (pready[g]),
      .PRDATA      (prdata[g]),
      .PSLVERR     (pslverr[g]),
      .addr        (addr_o[g]),
      .write_en    (wen[g]),
      .read_en     (ren[g]),
      .byte_strobe (bstrb[g]),
      .wdata       (wdata_o[g]),
      .rdata       (rdata[g])
    );
  end

  // Register-file models: combinational read, strobed write on write_en.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata[i] = ren[i] ? mem[i][addr_o[i][5:2]] : 32'h0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        for (int j = 0; j < 16; j++) mem[i][j] <= 32'h0;
      end else if (wen[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (bstrb[i][b]) mem[i][addr_o[i][5:2]][8*b +: 8] <= wdata_o[i][8*b +: 8];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input int g, input string tag);
    chk({tag, "_flags"}, {28'h0, pready[g], pslverr[g], wen[g], ren[g]}, 32'h0);
    chk({tag, "_prdata"}, prdata[g], 32'h0);
    chk({tag, "_addr"}, addr_o[g], 32'h0);
    chk({tag, "_wdata"}, wdata_o[g], 32'h0);
    chk({tag, "_strb"}, {28'h0, bstrb[g]}, 32'h0);
  endtask

  // Runs one transfer starting in the current cycle; returns in the cycle
  // after PREADY with the bus idle so a following call is back-to-back.
  task automatic apb_xfer(input int g, input logic [31:0] a, input logic w,
                          input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] rd, output logic err,
                          output int lat, output logic [1:0] saw);
    logic done;
    done = 1'b0; rd = '0; err = 1'b0; lat = 0; saw = '0;
    psel = '0; psel[g] = 1'b1; penable = 1'b0;
    paddr = a; pwrite = w; pstrb = s; pwdata = d;
    step();
    penable = 1'b1;
    for (int k = 1; k <= 40 && !done; k++) begin
      saw |= {wen[g], ren[g]};
      if (pready[g]) begin
        done = 1'b1; lat = k; rd = prdata[g]; err = pslverr[g];
      end else begin
        step();
      end
    end
    chk("xfer_completes", {31'h0, done}, 32'h1);
    step();
    psel = '0; penable = 1'b0; pwrite = 1'b0; pstrb = '0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  logic [1:0]  saw;
  logic        any_rdy, any_wen;

  initial begin
    // Reset state and first cycle after reset.
    step();
    step();
    for (int g = 0; g < 4; g++) chk_quiet(g, "in_reset");
    rst = 1'b0;
    step();
    for (int g = 0; g < 4; g++) chk_quiet(g, "post_reset");

    // Zero-wait write, cycle by cycle.
    psel = 4'b0001; penable = 1'b0; paddr = BASE + 32'h8; pwrite = 1'b1;
    pstrb = 4'hF; pwdata = 32'hDEADBEEF;
    step();
    penable = 1'b1;
    chk("zw_pready_T1", {31'h0, pready[0]}, 32'h1);
    chk("zw_wen_T1", {31'h0, wen[0]}, 32'h1);
    chk("zw_addr", addr_o[0], 32'h8);
    chk("zw_wdata", wdata_o[0], 32'hDEADBEEF);
    chk("zw_pslverr", {31'h0, pslverr[0]}, 32'h0);
    step();
    psel = '0; penable = 1'b0;
    chk("zw_pready_T2", {31'h0, pready[0]}, 32'h0);
    chk("zw_wen_T2", {31'h0, wen[0]}, 32'h0);
    chk("zw_mem", mem[0][2], 32'hDEADBEEF);

    // Waited read (3 wait states): preload, then check T1..T4.
    apb_xfer(2, BASE + 32'h4, 1'b1, 4'hF, 32'h12345678, rd, err, lat, saw);
    chk("w3_write_lat", lat, 32'd4);
    chk("w3_write_saw", {30'h0, saw}, 32'h2);
    psel = 4'b0100; penable = 1'b0; paddr = BASE + 32'h4; pwrite = 1'b0; pstrb = 4'h0;
    step();
    penable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("w3_pready_T%0d", k), {31'h0, pready[2]}, {31'h0, k == 4});
      chk($sformatf("w3_ren_T%0d", k), {31'h0, ren[2]}, 32'h1);
      if (k == 4) chk("w3_prdata_T4", prdata[2], 32'h12345678);
      else step();
    end
    step();
    psel = '0; penable = 1'b0;
    chk("w3_ren_T5", {31'h0, ren[2]}, 32'h0);

    // Error responses on the zero-wait instance.
    apb_xfer(0, BASE + 32'h40, 1'b1, 4'hF, 32'hFFFF0000, rd, err, lat, saw);
    chk("err_top_slverr", {31'h0, err}, 32'h1);
    chk("err_top_lat", lat, 32'd1);
    chk("err_top_saw", {30'h0, saw}, 32'h0);
    chk("err_top_prdata", rd, 32'h0);
    apb_xfer(0, BASE + 32'h2, 1'b1, 4'hF, 32'hFFFF0000, rd, err, lat, saw);
    chk("err_align_slverr", {31'h0, err}, 32'h1);
    chk("err_align_saw", {30'h0, saw}, 32'h0);
    chk("err_align_prdata", rd, 32'h0);
    apb_xfer(0, BASE + 32'h8, 1'b0, 4'h1, 32'h0, rd, err, lat, saw);
    chk("err_rdstrb_slverr", {31'h0, err}, 32'h1);
    chk("err_rdstrb_saw", {30'h0, saw}, 32'h0);
    chk("err_rdstrb_prdata", rd, 32'h0);
    apb_xfer(0, BASE - 32'h4, 1'b0, 4'h0, 32'h0, rd, err, lat, saw);
    chk("err_below_slverr", {31'h0, err}, 32'h1);
    chk("err_below_prdata", rd, 32'h0);
    apb_xfer(0, BASE + 32'h3C, 1'b1, 4'hF, 32'h0000003C, rd, err, lat, saw);
    chk("last_reg_slverr", {31'h0, err}, 32'h0);
    chk("last_reg_saw", {30'h0, saw}, 32'h2);
    apb_xfer(3, BASE + 32'h40, 1'b0, 4'h0, 32'h0, rd, err, lat, saw);
    chk("err_w4_slverr", {31'h0, err}, 32'h1);
    chk("err_w4_lat", lat, 32'd5);

    // Back-to-back write then read, plus a partial-strobe update.
    apb_xfer(0, BASE, 1'b1, 4'hF, 32'hA5A55A5A, rd, err, lat, saw);
    chk("b2b_wr_lat", lat, 32'd1);
    apb_xfer(0, BASE, 1'b0, 4'h0, 32'h0, rd, err, lat, saw);
    chk("b2b_rd_lat", lat, 32'd1);
    chk("b2b_rd_data", rd, 32'hA5A55A5A);
    chk("b2b_rd_saw", {30'h0, saw}, 32'h1);
    apb_xfer(0, BASE, 1'b1, 4'h3, 32'h11112222, rd, err, lat, saw);
    apb_xfer(0, BASE, 1'b0, 4'h0, 32'h0, rd, err, lat, saw);
    chk("strb_rd_data", rd, 32'hA5A52222);

    // Abort on the 4-wait instance: PSELx dropped in T2.
    psel = 4'b1000; penable = 1'b0; paddr = BASE + 32'hC; pwrite = 1'b1;
    pstrb = 4'hF; pwdata = 32'hCAFEF00D;
    step();
    penable = 1'b1;
    chk("abort_pready_T1", {31'h0, pready[3]}, 32'h0);
    step();
    psel = '0; penable = 1'b0;
    chk("abort_pready_T2", {31'h0, pready[3]}, 32'h0);
    step();
    any_rdy = 1'b0; any_wen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      any_rdy |= pready[3];
      any_wen |= wen[3];
      step();
    end
    chk("abort_no_pready", {31'h0, any_rdy}, 32'h0);
    chk("abort_no_wen", {31'h0, any_wen}, 32'h0);
    chk("abort_mem", mem[3][3], 32'h0);
    apb_xfer(3, BASE + 32'hC, 1'b1, 4'hF, 32'h0BADF00D, rd, err, lat, saw);
    chk("post_abort_wr_lat", lat, 32'd5);
    chk("post_abort_wr_saw", {30'h0, saw}, 32'h2);
    apb_xfer(3, BASE + 32'hC, 1'b0, 4'h0, 32'h0, rd, err, lat, saw);
    chk("post_abort_rd_data", rd, 32'h0BADF00D);

    // Reset in T2 of a 2-wait write.
    psel = 4'b0010; penable = 1'b0; paddr = BASE + 32'h10; pwrite = 1'b1;
    pstrb = 4'hF; pwdata = 32'h55AA55AA;
    step();
    penable = 1'b1;
    chk("rst_pready_T1", {31'h0, pready[1]}, 32'h0);
    step();
    chk("rst_wen_T2", {31'h0, wen[1]}, 32'h0);
    rst = 1'b1;
    step();
    psel = '0; penable = 1'b0; pwrite = 1'b0; pstrb = '0;
    chk_quiet(1, "rst_T3");
    rst = 1'b0;
    step();
    chk_quiet(1, "rst_T4");
    apb_xfer(1, BASE + 32'h10, 1'b1, 4'hF, 32'h600DCAFE, rd, err, lat, saw);
    chk("after_rst_wr_lat", lat, 32'd3);
    chk("after_rst_wr_slverr", {31'h0, err}, 32'h0);
    apb_xfer(1, BASE + 32'h10, 1'b0, 4'h0, 32'h0, rd, err, lat, saw);
    chk("after_rst_rd_data", rd, 32'h600DCAFE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_apb_slave_ws
